// File: rtl/lcd_scope_disp_if.sv
// lcd_scope_disp_if: UI pixel and waveform sample fetch handshake between the display engine and its sources
interface lcd_scope_disp_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CH_NUM = 2,
  parameter int WAVE_W = 8
);
  logic ui_req;
  logic [XW-1:0] ui_x;
  logic [YW-1:0] ui_y;
  logic [15:0] ui_pixel_data;
  logic wave_rd;
  logic [XW-1:0] wave_addr;
  logic [CH_NUM*WAVE_W-1:0] wave_data;
  modport master(output ui_req, ui_x, ui_y, wave_rd, wave_addr, input ui_pixel_data, wave_data);
  modport slave(input ui_req, ui_x, ui_y, wave_rd, wave_addr, output ui_pixel_data, wave_data);
endinterface

// File: rtl/lcd_scope_disp.sv
// lcd_scope_disp: RGB-LCD timing plus windowed multi-channel scope trace compositor; LCD_SCOPE_GRID_EN adds a dotted grid
module lcd_scope_disp #(
  parameter int H_SYNC = 41,
  parameter int H_BP = 2,
  parameter int H_DISP = 480,
  parameter int H_FP = 2,
  parameter int V_SYNC = 10,
  parameter int V_BP = 2,
  parameter int V_DISP = 272,
  parameter int V_FP = 2,
  parameter int WIN_X0 = 40,
  parameter int WIN_Y0 = 8,
  parameter int WIN_W = 400,
  parameter int WIN_H = 256,
  parameter int CH_NUM = 2,
  parameter int WAVE_W = 8,
  parameter logic [16*CH_NUM-1:0] CH_COLOR = {16'h07FF, 16'hFFE0},
  parameter logic [15:0] TRIG_COLOR = 16'hF800,
  parameter logic [15:0] BACK_COLOR = 16'h0000,
  parameter logic [15:0] GRID_COLOR = 16'h4208
) (
  input  logic lcd_pclk,
  input  logic rst_n,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [WAVE_W-1:0] trig_level,
  lcd_scope_disp_if.master bus,
  output logic frame_start,
  output logic frame_done,
  output logic lcd_de,
  output logic lcd_hs,
  output logic lcd_vs,
  output logic [15:0] lcd_rgb
);
  localparam int XW = $clog2(WIN_W);
  localparam int YW = $clog2(WIN_H);
  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int HA = H_SYNC + H_BP;
  localparam int VA = V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT0 = HW'(HA);
  localparam logic [HW-1:0] H_ACT1 = HW'(HA + H_DISP);
  localparam logic [HW-1:0] H_WIN0 = HW'(HA + WIN_X0);
  localparam logic [HW-1:0] H_WIN1 = HW'(HA + WIN_X0 + WIN_W);
  localparam logic [HW-1:0] H_WLAST = HW'(HA + WIN_X0 + WIN_W - 1);
  localparam logic [HW-1:0] H_SYNCW = HW'(H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT0 = VW'(VA);
  localparam logic [VW-1:0] V_ACT1 = VW'(VA + V_DISP);
  localparam logic [VW-1:0] V_WIN0 = VW'(VA + WIN_Y0);
  localparam logic [VW-1:0] V_WIN1 = VW'(VA + WIN_Y0 + WIN_H);
  localparam logic [VW-1:0] V_WLAST = VW'(VA + WIN_Y0 + WIN_H - 1);
  localparam logic [VW-1:0] V_SYNCW = VW'(V_SYNC);
  localparam logic [WAVE_W-1:0] S_MAX = WAVE_W'(WIN_H - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic de0, in_win, at_origin, last;
  logic [2:0] de_p, hs_p, vs_p;
  logic [CH_NUM-1:0] ch_en_lat, hit;
  logic [WAVE_W-1:0] trig_lat, r;
  logic req2;
  logic [XW-1:0] x2;
  logic [YW-1:0] y2;
  logic [15:0] win_rgb, rgb_nxt;

  assign de0 = h_cnt >= H_ACT0 && h_cnt < H_ACT1 && v_cnt >= V_ACT0 && v_cnt < V_ACT1;
  assign in_win = h_cnt >= H_WIN0 && h_cnt < H_WIN1 && v_cnt >= V_WIN0 && v_cnt < V_WIN1;
  assign at_origin = h_cnt == '0 && v_cnt == '0;
  assign last = h_cnt == H_WLAST && v_cnt == V_WLAST;
  assign lcd_de = de_p[2];
  assign lcd_hs = hs_p[2];
  assign lcd_vs = vs_p[2];

  always_ff @(posedge lcd_pclk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
    end

  // stage 1 issues the fetch; stage 2 sees the returned data alongside req2/x2/y2
  always_ff @(posedge lcd_pclk or negedge rst_n)
    if (!rst_n) begin
      bus.ui_req <= 1'b0;
      bus.wave_rd <= 1'b0;
      bus.ui_x <= '0;
      bus.ui_y <= '0;
      bus.wave_addr <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      ch_en_lat <= '0;
      trig_lat <= '0;
      req2 <= 1'b0;
      x2 <= '0;
      y2 <= '0;
      de_p <= '0;
      hs_p <= '1;
      vs_p <= '1;
      lcd_rgb <= '0;
    end else begin
      bus.ui_req <= in_win;
      bus.wave_rd <= in_win;
      bus.ui_x <= in_win ? XW'(h_cnt - H_WIN0) : '0;
      bus.wave_addr <= in_win ? XW'(h_cnt - H_WIN0) : '0;
      bus.ui_y <= in_win ? YW'(v_cnt - V_WIN0) : '0;
      frame_start <= at_origin;
      frame_done <= last;
      if (at_origin) begin
        ch_en_lat <= ch_en;
        trig_lat <= trig_level;
      end
      req2 <= bus.ui_req;
      x2 <= bus.ui_x;
      y2 <= bus.ui_y;
      de_p <= {de_p[1:0], de0};
      hs_p <= {hs_p[1:0], h_cnt >= H_SYNCW};
      vs_p <= {vs_p[1:0], v_cnt >= V_SYNCW};
      lcd_rgb <= rgb_nxt;
    end

  assign r = S_MAX - WAVE_W'(y2);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [WAVE_W-1:0] d, s, p, lo, hi, prev;
    assign d = bus.wave_data[c*WAVE_W +: WAVE_W];
    assign s = d > S_MAX ? S_MAX : d;
    // the first column of each row has no left neighbour, so it draws a single dot
    assign p = x2 == '0 ? s : prev;
    assign lo = s < p ? s : p;
    assign hi = s < p ? p : s;
    assign hit[c] = ch_en_lat[c] && r >= lo && r <= hi;
    always_ff @(posedge lcd_pclk or negedge rst_n)
      if (!rst_n) prev <= '0;
      else if (req2) prev <= s;
  end

  always_comb begin
    win_rgb = bus.ui_pixel_data;
`ifdef LCD_SCOPE_GRID_EN
    if ((32'(x2) % 50 == 0 || 32'(y2) % 32 == 0) && !x2[0] && !y2[0]) win_rgb = GRID_COLOR;
`endif
    if (r == trig_lat) win_rgb = TRIG_COLOR;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (hit[i]) win_rgb = CH_COLOR[16*i +: 16];
    rgb_nxt = !de_p[1] ? 16'h0000 : req2 ? win_rgb : BACK_COLOR;
  end
endmodule

// File: tb/tb_lcd_scope_disp.sv
// tb_lcd_scope_disp: directed checks of a shrunken 32x16 timing (24x12 active, 16x8 window at 4,2)
module tb_lcd_scope_disp;
  localparam int HT = 32, VT = 16, FR = HT * VT, HA = 6, VA = 3;

  logic lcd_pclk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ch_en = 2'b01;
  logic [7:0] trig_level = 8'd0;
  logic frame_start, frame_done, lcd_de, lcd_hs, lcd_vs;
  logic [15:0] lcd_rgb;
  logic [7:0] wave0 [16];
  logic [7:0] wave1 [16];
  logic [15:0] cap_rgb [FR];
  logic cap_de [FR];
  logic cap_hs [FR];
  logic cap_vs [FR];
  logic cap_fd [FR];
  int n_tests = 0;
  int n_fail = 0;

  lcd_scope_disp_if #(.XW(4), .YW(3), .CH_NUM(2), .WAVE_W(8)) bus();

  lcd_scope_disp #(
    .H_SYNC(4), .H_BP(2), .H_DISP(24), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_DISP(12), .V_FP(1),
    .WIN_X0(4), .WIN_Y0(2), .WIN_W(16), .WIN_H(8)
  ) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .ch_en(ch_en), .trig_level(trig_level),
    .bus(bus), .frame_start(frame_start), .frame_done(frame_done),
    .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  function automatic logic [15:0] ui_val(input logic [3:0] x, input logic [2:0] y);
    return {4'h1, 1'b0, y, 4'h0, x};
  endfunction

  // registered sources: data appears exactly one cycle after the request
  always @(posedge lcd_pclk) begin
    bus.ui_pixel_data <= bus.ui_req ? ui_val(bus.ui_x, bus.ui_y) : 16'h0;
    bus.wave_data <= bus.wave_rd ? {wave1[bus.wave_addr], wave0[bus.wave_addr]} : 16'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge lcd_pclk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin step(); n++; end while (!frame_start && n < 2 * FR);
    chk("fs_seen", frame_start, 1);
  endtask

  task automatic fs_period();
    int n = 0;
    do begin step(); n++; end while (!frame_start && n < 2 * FR);
    chk("fs_period", n, FR);
  endtask

  // capture index i holds the output for counter position i (row i/HT, column i%HT)
  task automatic grab(input int tog_i, input logic [1:0] tog_v);
    wait_fs();
    step();
    step();
    for (int i = 0; i < FR; i++) begin
      cap_rgb[i] = lcd_rgb;
      cap_de[i] = lcd_de;
      cap_hs[i] = lcd_hs;
      cap_vs[i] = lcd_vs;
      cap_fd[i] = frame_done;
      if (i == tog_i) ch_en = tog_v;
      step();
    end
  endtask

  function automatic logic [15:0] px(input int x, input int y);
    return cap_rgb[(VA + y) * HT + HA + x];
  endfunction

  function automatic int fd_count();
    int n = 0;
    for (int i = 0; i < FR; i++) if (cap_fd[i]) n++;
    return n;
  endfunction

  task automatic timing_chk();
    int hs = 0, vs = 0, de = 0, full = 0, ld;
    for (int i = 0; i < FR; i++) begin
      if (!cap_hs[i]) hs++;
      if (!cap_vs[i]) vs++;
      if (cap_de[i]) de++;
    end
    for (int l = 0; l < VT; l++) begin
      ld = 0;
      for (int h = 0; h < HT; h++) if (cap_de[l * HT + h]) ld++;
      if (ld == 24) full++;
    end
    chk("hs_low_cycles", hs, 64);
    chk("hs_edge", {cap_hs[3], cap_hs[4]}, 2'b01);
    chk("vs_low_cycles", vs, 64);
    chk("vs_edge", {cap_vs[63], cap_vs[64]}, 2'b01);
    chk("de_cycles", de, 288);
    chk("de_full_lines", full, 12);
    chk("de_start", {cap_de[VA * HT + HA - 1], cap_de[VA * HT + HA]}, 2'b01);
    chk("de_end", {cap_de[VA * HT + HA + 23], cap_de[VA * HT + HA + 24]}, 2'b10);
    chk("fd_count", fd_count(), 1);
    chk("fd_pos", cap_fd[407], 1);
    chk("rgb_blank", cap_rgb[0], 0);
  endtask

  initial begin
    int nc;
    for (int a = 0; a < 16; a++) begin
      wave0[a] = 8'd4;
      wave1[a] = 8'd1;
    end
    repeat (3) step();
    chk("rst_hs", lcd_hs, 1);
    chk("rst_vs", lcd_vs, 1);
    chk("rst_de", lcd_de, 0);
    chk("rst_rgb", lcd_rgb, 0);
    chk("rst_req", {bus.ui_req, bus.wave_rd}, 0);
    chk("rst_xy", {bus.ui_x, bus.ui_y, bus.wave_addr}, 0);
    chk("rst_frame", {frame_start, frame_done}, 0);
    @(negedge lcd_pclk) rst_n = 1'b1;
    step();
    chk("fs_first_edge", frame_start, 1);
    fs_period();

    // constant trace: ch0=4 -> row y=5, trig 0 -> row y=9, ch1 disabled
    grab(-1, 2'b00);
    timing_chk();
    chk("const_left", px(4, 5), 16'hFFE0);
    chk("const_right", px(19, 5), 16'hFFE0);
    chk("const_out_l", px(3, 5), 16'h0000);
    chk("const_out_r", px(20, 5), 16'h0000);
    chk("const_out_top", px(10, 1), 16'h0000);
    chk("const_ui", px(10, 2), 16'h1006);
    chk("const_ch1_off", px(10, 8), 16'h1606);
    chk("const_trig", px(10, 9), 16'hF800);
    nc = 0;
    for (int i = 0; i < FR; i++) if (cap_rgb[i] == 16'hFFE0) nc++;
    chk("const_trace_px", nc, 16);

    // mid-frame enable change takes effect only from the next frame
    grab(100, 2'b10);
    chk("latch_old_ch0", px(4, 5), 16'hFFE0);
    chk("latch_old_ch1", px(10, 8), 16'h1606);
    chk("latch_fd", fd_count(), 1);
    grab(-1, 2'b10);
    chk("latch_new_ch1", px(10, 8), 16'h07FF);
    chk("latch_new_ch0", px(10, 5), 16'h1306);
    chk("latch_fd2", fd_count(), 1);

    // step fill with clipping and first-column restart
    for (int a = 0; a < 16; a++) wave0[a] = 8'd3;
    wave0[5] = 8'd1;
    wave0[6] = 8'd200;
    wave0[15] = 8'd6;
    ch_en = 2'b01;
    trig_level = 8'd255;
    grab(-1, 2'b01);
    chk("fill_top_clip", px(10, 2), 16'hFFE0);
    chk("fill_bot", px(10, 8), 16'hFFE0);
    chk("fill_below", px(10, 9), 16'h1706);
    chk("fill_c5_r1", px(9, 8), 16'hFFE0);
    chk("fill_c5_r4", px(9, 5), 16'h1305);
    chk("fill_c7_r3", px(11, 6), 16'hFFE0);
    chk("fill_c7_r2", px(11, 7), 16'h1507);
    chk("fill_c0_dot", px(4, 6), 16'hFFE0);
    chk("fill_c0_norst", px(4, 5), 16'h1300);

    // priority on a shared row r=3 (y=6)
    for (int a = 0; a < 16; a++) begin
      wave0[a] = 8'd3;
      wave1[a] = 8'd3;
    end
    trig_level = 8'd3;
    ch_en = 2'b11;
    grab(-1, 2'b11);
    chk("prio_ch0", px(10, 6), 16'hFFE0);
    chk("prio_ui", px(10, 5), 16'h1306);
    ch_en = 2'b10;
    grab(-1, 2'b10);
    chk("prio_ch1", px(10, 6), 16'h07FF);
    ch_en = 2'b00;
    grab(-1, 2'b00);
    chk("prio_trig", px(10, 6), 16'hF800);
    chk("prio_ui2", px(10, 7), 16'h1506);

    // reset in the middle of an active window line
    wait_fs();
    repeat (206) step();
    chk("pre_rst_rgb", lcd_rgb, 16'h1102);
    chk("pre_rst_de", lcd_de, 1);
    chk("pre_rst_req", bus.ui_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", lcd_rgb, 0);
    chk("mid_rst_sync", {lcd_hs, lcd_vs, lcd_de}, 3'b110);
    chk("mid_rst_req", bus.ui_req, 0);
    repeat (3) @(negedge lcd_pclk);
    rst_n = 1'b1;
    step();
    chk("rst_fs_first_edge", frame_start, 1);
    fs_period();
    grab(-1, 2'b00);
    timing_chk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_scope_disp.md
# lcd_scope_disp

Parametrised LCD scope display engine for the oscilloscope datapath. It generates RGB-LCD timing and places a clip window inside the active area. It fetches UI and multi-channel waveform samples with registered request/return handshakes, and composites traces, trigger line and background into a latency-matched RGB565 stream. It replaces the fixed 480x272, single-channel top-level path, adding per-channel enables, vertical trace fill between samples, and frame-boundary buffer handshakes.

## Interface
- H_SYNC, 41: hsync width, pclk cycles
- H_BP, 2: horizontal back porch
- H_DISP, 480: active pixels per line
- H_FP, 2: horizontal front porch
- V_SYNC, 10: vsync width, lines
- V_BP, 2: vertical back porch
- V_DISP, 272: active lines
- V_FP, 2: vertical front porch
- WIN_X0, 40 / WIN_Y0, 8: window origin in active coordinates
- WIN_W, 400 / WIN_H, 256: window size. Constraints: WIN_X0+WIN_W ≤ H_DISP, WIN_Y0+WIN_H ≤ V_DISP, WIN_H ≤ 2^WAVE_W.
- CH_NUM, 2: waveform channels. Channel 0 has the highest priority.
- WAVE_W, 8: sample width
- CH_COLOR, {16'h07FF,16'hFFE0}: packed RGB565, channel c at [16c+15:16c]
- TRIG_COLOR, 16'hF800 / BACK_COLOR, 16'h0000 / GRID_COLOR, 16'h4208
- Derived: XW=$clog2(WIN_W), YW=$clog2(WIN_H)

Ports:
- lcd_pclk in 1: pixel clock
- rst_n in 1: reset, asynchronous, active-low. Clock lcd_pclk.
- ch_en in CH_NUM: channel enables, sampled at frame_start
- trig_level in WAVE_W: trigger row value, sampled at frame_start
- ui_req out 1: UI pixel request
- ui_x out XW, ui_y out YW: window-relative request coordinates
- ui_pixel_data in 16: returned one cycle after ui_req
- wave_rd out 1: waveform read strobe
- wave_addr out XW: sample index (= ui_x)
- wave_data in CH_NUM*WAVE_W: returned one cycle after wave_rd
- frame_start out 1: pulse at h_cnt=0, v_cnt=0
- frame_done out 1: pulse when the last window request is issued
- lcd_de, lcd_hs, lcd_vs out 1: de active-high; hs and vs active-low
- lcd_rgb out 16: RGB565 pixel

## Operation
- Counters h_cnt wrap at H_TOTAL-1 and v_cnt wrap at V_TOTAL-1 (totals are sums of sync, porch and active). Active when h_cnt ∈ [H_SYNC+H_BP, +H_DISP) and v_cnt likewise.
- Window membership uses active-relative x,y. In-window, stage 1 registers ui_req=wave_rd=1, ui_x=wave_addr=x-WIN_X0 and ui_y=y-WIN_Y0.
- Stage 2 receives the returned data.
  - Sample s_c = min(wave_data[c], WIN_H-1).
  - prev_c holds the previous column's s_c. At ui_x=0, prev_c=s_c.
  - Row r = WIN_H-1-ui_y.
  - Channel c hits when ch_en_lat[c] && min(s_c,prev_c) ≤ r ≤ max(s_c,prev_c).
- Pixel priority:
  1. Lowest-index hit channel → CH_COLOR[c]
  2. r == trig_lat → TRIG_COLOR
  3. Grid (if compiled in)
  4. ui_pixel_data
- Outside the window but active: BACK_COLOR. Inactive: lcd_rgb=0.
- frame_start latches ch_en and trig_level. Mid-frame changes have no effect until the next frame_start.
- frame_done fires with the request for (WIN_W-1, WIN_H-1). The writer may swap buffers after it.

## Timing
- Pixel latency is 3 lcd_pclk cycles:
  - counter position → stage-1 request (registered)
  - data return
  - registered lcd_rgb
- lcd_de, lcd_hs and lcd_vs are delayed 3 cycles to align with lcd_rgb.
- External sources must return data exactly one cycle after the request. There is no backpressure.
- Reset values:
  - lcd_hs=1, lcd_vs=1.
  - lcd_de, lcd_rgb, ui_req, wave_rd, ui_x, ui_y, wave_addr, frame_start, frame_done all 0.
  - Counters 0. ch_en_lat=0, trig_lat=0.
  - Delay pipes flushed to the reset values.
- Reset mid-frame: outputs take reset values immediately (asynchronous). After release, counting restarts at (0,0) and frame_start pulses on the first clock edge.
- Simultaneous hits on several channels or on the trigger row resolve strictly by the priority list.

## Configuration
- LCD_SCOPE_GRID_EN defined: in-window pixels with (ui_x%50==0 or ui_y%32==0) and both ui_x and ui_y even render GRID_COLOR (below traces and trigger, above UI).
- LCD_SCOPE_GRID_EN undefined: no grid logic; those pixels show ui_pixel_data.

## Test plan
- Timing, defaults:
  - lcd_hs low 41 of every 525 cycles
  - lcd_vs low 10 of every 286 lines
  - lcd_de high 480 contiguous cycles per active line, 272 lines per frame
  - frame_start period 525*286 cycles
- Constant trace: ch_en=01, ch0 samples all 128, trig_level=0.
  - Active y=135 (r=128), x=40..439: lcd_rgb=16'hFFE0.
  - Other window pixels: UI data.
  - Outside window: 0x0000.
- Step fill: ch0 sample 10 at addr 99, 200 at addr 100, ch_en=01.
  - Column x=140: r=10..200 (y=63..253) show 16'hFFE0.
  - Column x=139 shows only r=10.
- Priority: ch0=ch1=50, trig_level=50, ch_en=11.
  - Row r=50 shows 16'hFFE0.
  - ch_en=10 → 16'h07FF.
  - ch_en=00 → 16'hF800.
- Enable latching: toggle ch_en mid-frame.
  - Traces change only after the next frame_start.
  - frame_done pulses once per frame, at the request for (399,255).
- Reset mid-line: assert rst_n low at h_cnt=300.
  - lcd_hs=lcd_vs=1, lcd_rgb=0 at once.
  - After release, frame_start pulses at the first edge and timing matches test 1.
